// File: rtl/config_port_arbiter_if.sv
// Bundle of requester and BRAM port-B signals shared by config_port_arbiter and its users.
// master: requesters plus the BRAM read-data return; slave: the arbiter.
interface config_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      bram_we;
  logic [ADDR_W-1:0]         bram_addr;
  logic [DATA_W-1:0]         bram_din;
  logic [DATA_W-1:0]         bram_dout;

  modport master (
    output req, req_we, req_addr, req_din, bram_dout,
    input  gnt, rvalid, rdata, bram_we, bram_addr, bram_din
  );

  modport slave (
    input  req, req_we, req_addr, req_din, bram_dout,
    output gnt, rvalid, rdata, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/config_port_arbiter.sv
// Round-robin arbiter sharing config BRAM port B among NUM_REQ requesters, with read-owner tracking.
// Optional macro CFG_ARB_FIXED_PRIO_EN: requester 0 always wins when eligible, others round-robin.
module config_port_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic                  CLK,
  input logic                  RST_N,
  config_port_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RD_LATENCY-1:0] own_v_q;
  logic [PTR_W-1:0]     own_id_q [RD_LATENCY];
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic [NUM_REQ-1:0]   pend, elig, rr_elig;
  logic                 found, rd_issue;
  logic [PTR_W-1:0]     win;
  logic [PTR_W:0]       idx;

  // A requester stays blocked from read grant through the cycle of its RVALID
  always_comb begin
    pend = rvalid_q;
    for (int j = 0; j < int'(RD_LATENCY); j++) begin
      if (own_v_q[j]) pend[own_id_q[j]] = 1'b1;
    end
    elig = bus.req & ~pend;
  end

  // Winner selection, searching upward from the pointer with wrap
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    rr_elig = elig;
`ifdef CFG_ARB_FIXED_PRIO_EN
    rr_elig[0] = 1'b0;
    if (elig[0]) found = 1'b1;
`endif
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && rr_elig[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    rr_ptr_d = rr_ptr_q;
    rd_issue = 1'b0;

    case (state_q)
      IDLE, HOLD: begin
        if (found)          state_d = ISSUE;
        else if (|bus.req)  state_d = HOLD;
      end
      ISSUE: begin
        if (!found) state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
    if (bus.req == '0) state_d = IDLE;

    if (found) begin
      gnt_d    = NUM_REQ'(1) << win;
      we_d     = bus.req_we[win];
      addr_d   = bus.req_addr[win*ADDR_W +: ADDR_W];
      din_d    = bus.req_din[win*DATA_W +: DATA_W];
      rd_issue = ~bus.req_we[win];
      rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef CFG_ARB_FIXED_PRIO_EN
      if (win == '0) rr_ptr_d = rr_ptr_q;
`endif
    end

    rvalid_d = own_v_q[RD_LATENCY-1] ? (NUM_REQ'(1) << own_id_q[RD_LATENCY-1]) : '0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      own_v_q  <= '0;
      for (int j = 0; j < int'(RD_LATENCY); j++) own_id_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      own_v_q[0]  <= rd_issue;
      own_id_q[0] <= win;
      for (int j = 1; j < int'(RD_LATENCY); j++) begin
        own_v_q[j]  <= own_v_q[j-1];
        own_id_q[j] <= own_id_q[j-1];
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.bram_we   = we_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din  = din_q;
  // BRAM output is valid in the RVALID cycle itself, so it is gated rather than re-registered
  assign bus.rdata     = (|rvalid_q) ? bus.bram_dout : '0;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Scoreboard bench for config_port_arbiter: directed requests push expected grants/reads, a monitor checks them.
module tb_config_port_arbiter;
  localparam int unsigned NR = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 16;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  config_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  config_port_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  typedef struct {
    logic [NR-1:0] gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    int            cyc;
  } gexp_t;

  typedef struct {
    logic [NR-1:0] rv;
    logic [DW-1:0] data;
  } rexp_t;

  gexp_t exp_g[$];
  rexp_t exp_r[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rv_seen = 0;
  int cnt[NR];
  int gcyc[NR];
  logic [DW-1:0] mem [64];
  logic [DW-1:0] pipe0, pipe1;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;

  // Two-cycle-latency BRAM model with preloaded read data
  always @(posedge CLK) begin
    if (!RST_N) begin
      mem[13] <= 16'h1234;
      mem[5]  <= 16'h0555;
    end else if (bus.bram_we) begin
      mem[bus.bram_addr] <= bus.bram_din;
    end
    pipe0 <= mem[bus.bram_addr];
    pipe1 <= pipe0;
  end
  assign bus.bram_dout = pipe1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_g(input logic [NR-1:0] g, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input int c);
    exp_g.push_back('{g, w, a, d, c});
  endfunction

  function automatic void push_r(input logic [NR-1:0] v, input logic [DW-1:0] d);
    exp_r.push_back('{v, d});
  endfunction

  // Monitor: pops the scoreboard whenever a grant or read response appears
  always @(posedge CLK) begin
    gexp_t e;
    rexp_t r;
    #1;
    if (!RST_N) begin
      last_addr = '0;
      last_din  = '0;
    end else begin
      if (bus.gnt != '0) begin
        if (exp_g.size() == 0) begin
          check("gnt_unexpected", 32'(bus.gnt), 32'(0));
        end else begin
          e = exp_g.pop_front();
          check("gnt", 32'(bus.gnt), 32'(e.gnt));
          check("bram_we", 32'(bus.bram_we), 32'(e.we));
          check("bram_addr", 32'(bus.bram_addr), 32'(e.addr));
          check("bram_din", 32'(bus.bram_din), 32'(e.din));
          if (e.cyc >= 0) check("gnt_cycle", 32'(cyc), 32'(e.cyc));
        end
        for (int i = 0; i < int'(NR); i++) if (bus.gnt[i] && !bus.bram_we) gcyc[i] = cyc;
        last_addr = bus.bram_addr;
        last_din  = bus.bram_din;
      end else begin
        check("idle_hold", 32'({bus.bram_we, bus.bram_addr, bus.bram_din}),
              32'({1'b0, last_addr, last_din}));
      end
      if (bus.rvalid != '0) begin
        rv_seen++;
        if (exp_r.size() == 0) begin
          check("rvalid_unexpected", 32'(bus.rvalid), 32'(0));
        end else begin
          r = exp_r.pop_front();
          check("rvalid", 32'(bus.rvalid), 32'(r.rv));
          check("rdata", 32'(bus.rdata), 32'(r.data));
          for (int i = 0; i < int'(NR); i++)
            if (bus.rvalid[i]) check("rd_latency", 32'(cyc), 32'(gcyc[i] + 2));
        end
      end
    end
  end

  // Advance one cycle; drop a request once it has received its quota of grants
  task automatic tick();
    @(posedge CLK);
    #1;
    for (int i = 0; i < int'(NR); i++) begin
      if (bus.gnt[i] && cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) bus.req[i] = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  task automatic req_set(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int n);
    bus.req_we[i]          = we;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_din[i*DW +: DW]  = d;
    cnt[i]                 = n;
    bus.req[i]             = 1'b1;
  endtask

  task automatic apply_reset(input string tag);
    RST_N   = 1'b0;
    bus.req = '0;
    for (int i = 0; i < int'(NR); i++) cnt[i] = 0;
    #1;
    check({tag, "_gnt"},    32'(bus.gnt),       32'(0));
    check({tag, "_rvalid"}, 32'(bus.rvalid),    32'(0));
    check({tag, "_rdata"},  32'(bus.rdata),     32'(0));
    check({tag, "_we"},     32'(bus.bram_we),   32'(0));
    check({tag, "_addr"},   32'(bus.bram_addr), 32'(0));
    check({tag, "_din"},    32'(bus.bram_din),  32'(0));
    tick();
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  initial begin
    int c;
    int rv0;
    bus.req      = '0;
    bus.req_we   = '0;
    bus.req_addr = '0;
    bus.req_din  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      cnt[i]  = 0;
      gcyc[i] = 0;
    end
    @(negedge CLK);
    apply_reset("por");

    // Single read right after reset: grant in the second cycle after release
    c = cyc;
    req_set(1, 1'b0, 6'h0D, 16'h0000, 1);
    push_g(3'b010, 1'b0, 6'h0D, 16'h0000, c + 1);
    push_r(3'b010, 16'h1234);
    repeat (6) tick();

    // Contention, all writes held
    apply_reset("rst_b");
    c = cyc;
    req_set(0, 1'b1, 6'h20, 16'hA000, 2);
    req_set(1, 1'b1, 6'h21, 16'hA001, 1);
    req_set(2, 1'b1, 6'h22, 16'hA002, 1);
`ifdef CFG_ARB_FIXED_PRIO_EN
    push_g(3'b001, 1'b1, 6'h20, 16'hA000, c + 1);
    push_g(3'b001, 1'b1, 6'h20, 16'hA000, c + 2);
    push_g(3'b010, 1'b1, 6'h21, 16'hA001, c + 3);
    push_g(3'b100, 1'b1, 6'h22, 16'hA002, c + 4);
`else
    push_g(3'b001, 1'b1, 6'h20, 16'hA000, c + 1);
    push_g(3'b010, 1'b1, 6'h21, 16'hA001, c + 2);
    push_g(3'b100, 1'b1, 6'h22, 16'hA002, c + 3);
    push_g(3'b001, 1'b1, 6'h20, 16'hA000, c + 4);
`endif
    repeat (6) tick();

    // Continuous reads by 0 are spaced out; a write from 2 fills the gap
    c = cyc;
    req_set(0, 1'b0, 6'h05, 16'h0000, 3);
    push_g(3'b001, 1'b0, 6'h05, 16'h0000, c + 1);
    repeat (3) push_r(3'b001, 16'h0555);
    tick();
    tick();
    req_set(2, 1'b1, 6'h2A, 16'h5A5A, 1);
    push_g(3'b100, 1'b1, 6'h2A, 16'h5A5A, c + 3);
    push_g(3'b001, 1'b0, 6'h05, 16'h0000, c + 5);
    push_g(3'b001, 1'b0, 6'h05, 16'h0000, c + 9);
    repeat (14) tick();

    // Write then read of the same address in consecutive cycles
    c = cyc;
    req_set(2, 1'b1, 6'h13, 16'hBEEF, 1);
    push_g(3'b100, 1'b1, 6'h13, 16'hBEEF, c + 1);
    tick();
    req_set(0, 1'b0, 6'h13, 16'h0000, 1);
    push_g(3'b001, 1'b0, 6'h13, 16'h0000, c + 2);
    push_r(3'b001, 16'hBEEF);
    repeat (6) tick();

    // Reset in the cycle after a read grant discards the read
    c   = cyc;
    rv0 = rv_seen;
    req_set(1, 1'b0, 6'h0D, 16'h0000, 1);
    push_g(3'b010, 1'b0, 6'h0D, 16'h0000, c + 1);
    tick();
    tick();
    apply_reset("midrd");
    repeat (6) tick();
    check("no_rvalid_after_reset", 32'(rv_seen), 32'(rv0));

    // Requesters 0 and 2 writing, held
    c = cyc;
    req_set(0, 1'b1, 6'h30, 16'h3000, 2);
    req_set(2, 1'b1, 6'h32, 16'h3002, 2);
`ifdef CFG_ARB_FIXED_PRIO_EN
    push_g(3'b001, 1'b1, 6'h30, 16'h3000, c + 1);
    push_g(3'b001, 1'b1, 6'h30, 16'h3000, c + 2);
    push_g(3'b100, 1'b1, 6'h32, 16'h3002, c + 3);
    push_g(3'b100, 1'b1, 6'h32, 16'h3002, c + 4);
`else
    push_g(3'b001, 1'b1, 6'h30, 16'h3000, c + 1);
    push_g(3'b100, 1'b1, 6'h32, 16'h3002, c + 2);
    push_g(3'b001, 1'b1, 6'h30, 16'h3000, c + 3);
    push_g(3'b100, 1'b1, 6'h32, 16'h3002, c + 4);
`endif
    repeat (6) tick();

    check("grants_outstanding", 32'(exp_g.size()), 32'(0));
    check("reads_outstanding", 32'(exp_r.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/config_port_arbiter.md
CONFIG_PORT_ARBITER -- requirements
Module: config_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing config BRAM port B; legal range 2..8.
REQ-002 Parameter ADDR_W, default 6: BRAM word address width.
REQ-003 Parameter DATA_W, default 16: BRAM data width.
REQ-004 Parameter RD_LATENCY, default 2: BRAM port-B read latency in cycles, from address registered to data valid; legal range 1..4.
REQ-005 CLK  in  1  single clock; all logic is on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 REQ  in  NUM_REQ  per-requester access request, level, held until granted.
REQ-008 REQ_WE  in  NUM_REQ  per-requester write enable (1 = write, 0 = read), valid while REQ is high.
REQ-009 REQ_ADDR  in  NUM_REQ*ADDR_W  per-requester address; requester i owns slice i.
REQ-010 REQ_DIN  in  NUM_REQ*DATA_W  per-requester write data; requester i owns slice i.
REQ-011 GNT  out  NUM_REQ  one-hot, one-cycle grant pulse.
REQ-012 RVALID  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse.
REQ-013 RDATA  out  DATA_W  shared read data; valid only while some RVALID bit is high.
REQ-014 BRAM_WE  out  1  port-B write enable.
REQ-015 BRAM_ADDR  out  ADDR_W  port-B address.
REQ-016 BRAM_DIN  out  DATA_W  port-B write data.
REQ-017 BRAM_DOUT  in  DATA_W  port-B read data.

Function
REQ-018 State machine states: IDLE (no eligible request), ISSUE (an access is driven this cycle), HOLD (eligible requests exist but all are blocked).
REQ-019 Eligible requester: REQ high and no outstanding read of its own.
REQ-020 Each cycle, if any requester is eligible, exactly one winner is selected, round-robin, starting from the index after the last winner.
REQ-021 Winner's GNT pulses in the cycle after REQ is sampled; in that same cycle BRAM_ADDR, BRAM_WE and BRAM_DIN are registered copies of the winner's inputs.
REQ-022 Read grant issued in cycle t: RVALID[winner] high and RDATA = BRAM_DOUT in cycle t+RD_LATENCY.
REQ-023 Owner tracking: a RD_LATENCY-deep shift register of {valid, id}.
REQ-024 A requester with a read in flight is ineligible until the cycle after its RVALID.
REQ-025 Writes have no response; a writer is eligible again on the cycle after its GNT.
REQ-026 A requester that holds REQ high after its GNT is granted again by round-robin; back-to-back grants, one per cycle, are legal.
REQ-027 BRAM_WE is high only in a cycle where GNT carries a write; in every other cycle it is 0.
REQ-028 Idle cycles: BRAM_ADDR and BRAM_DIN hold their last value.
REQ-029 Writes and reads to the same address in consecutive cycles are issued in grant order, with no reordering.
REQ-030 State transitions:
- IDLE -> ISSUE on an eligible request.
- ISSUE -> ISSUE while eligible requests remain.
- ISSUE -> HOLD when requests exist but none is eligible.
- HOLD -> ISSUE when a blocking read returns.
- Any state -> IDLE when REQ is all zero.

Reset
REQ-031 On RST_N low:
- GNT, RVALID, RDATA, BRAM_WE, BRAM_ADDR and BRAM_DIN = 0.
- State = IDLE; round-robin pointer = index 0 highest priority.
- Owner shift register cleared.
REQ-032 Reset asserted mid-operation discards in-flight reads; no RVALID is produced for them after reset release.
REQ-033 First grant is possible in the second cycle after RST_N deasserts.

Configuration
REQ-034 Macro CFG_ARB_FIXED_PRIO_EN: when defined, requester 0 always wins when eligible, and the others are round-robin among themselves; when undefined, all requesters are pure round-robin.

Verification
REQ-035 Single read: REQ[1]=1, read, addr 0x0D, BRAM holds 0x1234 -> GNT[1] one cycle later; RVALID[1] with RDATA=0x1234 two cycles after GNT.
REQ-036 Contention: REQ=3'b111, all writes, held high -> grants in order 0,1,2,0; BRAM_WE high each cycle; addresses match the owners.
REQ-037 Blocking: REQ[0] reads continuously -> GNT[0] no more often than once every 3 cycles; REQ[2] write inserted in the gap is granted there.
REQ-038 Ordering: write 0xBEEF to 0x13 by requester 2, then read 0x13 by requester 0 -> RDATA=0xBEEF.
REQ-039 Reset mid-read: RST_N low in the cycle after GNT[1] for a read -> no RVALID ever asserted; all outputs 0 during reset.
REQ-040 CFG_ARB_FIXED_PRIO_EN defined, REQ=3'b101 with writes held -> requester 0 wins every cycle; undefined -> grants alternate 0,2.
